llc_input_arbiter: RTL and testbench

Arbitrates the LLC's five work sources into the single decode/read-set pipeline slot: the internal resume source plus four external channels (coherence response, testbench reset/flush, coherence request, DMA request). It sits between the input channel FIFOs and the LLC input decoder. It holds one registered grant toward the decoder FIFO and enforces the stall rules. Bounded starvation counters keep DMA and requests from being locked out indefinitely by higher-priority traffic.

---
 rtl/llc_input_arbiter_pkg.sv | 24 ++
 rtl/llc_input_arbiter_starve_cnt.sv | 44 ++++
 rtl/llc_input_arbiter.sv | 148 ++++++++++++++
 tb/tb_llc_input_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_input_arbiter_pkg.sv
// rtl/llc_input_arbiter_pkg.sv - source codes, FSM states and defaults for the LLC input arbiter
package llc_input_arbiter_pkg;

  // Default starvation bound and counter width; the limit must fit in the counter
  localparam int LLC_ARB_STARVE_LIMIT = 8;
  localparam int LLC_ARB_CNT_W        = 4;

  // Source code carried in out_sel toward the decoder FIFO
  typedef enum logic [2:0] {
    LLC_ARB_NONE   = 3'd0,
    LLC_ARB_RESUME = 3'd1,
    LLC_ARB_RSP    = 3'd2,
    LLC_ARB_RST_TB = 3'd3,
    LLC_ARB_REQ    = 3'd4,
    LLC_ARB_DMA    = 3'd5
  } llc_arb_sel_t;

  // ARB: normal arbitration; RST_BLOCK: a reset/flush is in flight
  typedef enum logic {
    LLC_ARB_ST_ARB       = 1'b0,
    LLC_ARB_ST_RST_BLOCK = 1'b1
  } llc_arb_state_t;

endpackage

// File: rtl/llc_input_arbiter_starve_cnt.sv
// rtl/llc_input_arbiter_starve_cnt.sv - saturating lost-round counter for one arbitration channel
module llc_starve_cnt
  import llc_input_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = LLC_ARB_STARVE_LIMIT,
  parameter int CNT_W        = LLC_ARB_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic lost,
  input  logic won,
  output logic sat
);

  localparam logic [CNT_W-1:0] LIMIT = STARVE_LIMIT[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count rounds lost while eligible, clear on a win, stop at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (won) begin
        cnt_d = '0;
      end else if (lost && (cnt_q != LIMIT)) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == LIMIT);

endmodule

// File: rtl/llc_input_arbiter.sv
// rtl/llc_input_arbiter.sv - five-source priority arbiter feeding the LLC decode/read-set slot
module llc_input_arbiter
  import llc_input_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = LLC_ARB_STARVE_LIMIT,
  parameter int CNT_W        = LLC_ARB_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       resume_valid,
  output logic       resume_ready,
  input  logic       rsp_valid,
  output logic       rsp_ready,
  input  logic       rst_tb_valid,
  output logic       rst_tb_ready,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       dma_valid,
  output logic       dma_ready,
  input  logic       req_stall,
  input  logic       flush_stall,
  input  logic       rst_done,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_sel,
  output logic       busy
);

  llc_arb_state_t state_q, state_d;
  logic           out_valid_q, out_valid_d;
  llc_arb_sel_t   out_sel_q, out_sel_d;

  llc_arb_sel_t   win;
  logic           arb_mode;
  logic           rst_tb_can;
  logic           req_can;
  logic           dma_can;
  logic           load;
  logic           fire;
  logic           req_sat;
  logic           dma_sat;
  logic           req_won;
  logic           dma_won;
  logic           req_lost;
  logic           dma_lost;

  // Eligibility and priority pick; a saturated dma/req jumps above rst_tb and req but never above resume/rsp
  always_comb begin
    arb_mode   = (state_q == LLC_ARB_ST_ARB);
    rst_tb_can = rst_tb_valid && arb_mode;
    req_can    = req_valid && !req_stall && !flush_stall && arb_mode;
    dma_can    = dma_valid && !flush_stall && arb_mode;

    win = LLC_ARB_NONE;
    if (resume_valid) begin
      win = LLC_ARB_RESUME;
    end else if (rsp_valid) begin
      win = LLC_ARB_RSP;
    end else if (dma_can && dma_sat) begin
      win = LLC_ARB_DMA;
    end else if (req_can && req_sat) begin
      win = LLC_ARB_REQ;
    end else if (rst_tb_can) begin
      win = LLC_ARB_RST_TB;
    end else if (req_can) begin
      win = LLC_ARB_REQ;
    end else if (dma_can) begin
      win = LLC_ARB_DMA;
    end
  end

  // The slot can take a new grant when empty or draining; reset suppresses every handshake
  assign load = !out_valid_q || out_ready;
  assign fire = load && !rst;

  assign resume_ready = fire && (win == LLC_ARB_RESUME);
  assign rsp_ready    = fire && (win == LLC_ARB_RSP);
  assign rst_tb_ready = fire && (win == LLC_ARB_RST_TB);
  assign req_ready    = fire && (win == LLC_ARB_REQ);
  assign dma_ready    = fire && (win == LLC_ARB_DMA);

  assign req_won  = (win == LLC_ARB_REQ);
  assign dma_won  = (win == LLC_ARB_DMA);
  assign req_lost = req_can && !req_won;
  assign dma_lost = dma_can && !dma_won;

  llc_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_req_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (fire),
    .lost (req_lost),
    .won  (req_won),
    .sat  (req_sat)
  );

  llc_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_dma_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (fire),
    .lost (dma_lost),
    .won  (dma_won),
    .sat  (dma_sat)
  );

  // Next grant register and FSM state; rst_done only matters while blocked
  always_comb begin
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    state_d     = state_q;
    if (fire) begin
      out_valid_d = (win != LLC_ARB_NONE);
      out_sel_d   = win;
    end
    if (state_q == LLC_ARB_ST_ARB) begin
      if (fire && (win == LLC_ARB_RST_TB)) begin
        state_d = LLC_ARB_ST_RST_BLOCK;
      end
    end else begin
      if (rst_done) begin
        state_d = LLC_ARB_ST_ARB;
      end
    end
  end

  // FSM state and registered grant toward the decoder
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LLC_ARB_ST_ARB;
      out_valid_q <= 1'b0;
      out_sel_q   <= LLC_ARB_NONE;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign busy      = (state_q == LLC_ARB_ST_RST_BLOCK);

endmodule

// File: tb/tb_llc_input_arbiter.sv
// tb/tb_llc_input_arbiter.sv - self-checking bench for llc_input_arbiter
module tb_llc_input_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       resume_valid = 1'b0, rsp_valid = 1'b0, rst_tb_valid = 1'b0;
  logic       req_valid = 1'b0, dma_valid = 1'b0;
  logic       req_stall = 1'b0, flush_stall = 1'b0, rst_done = 1'b0, out_ready = 1'b0;
  logic       resume_ready, rsp_ready, rst_tb_ready, req_ready, dma_ready;
  logic       out_valid, busy;
  logic [2:0] out_sel;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit  m_valid;
  int  m_sel;
  bit  m_blk;
  int  m_req_cnt;
  int  m_dma_cnt;
  bit  can[6];
  int  order[5];

  localparam int LIMIT = 8;

  llc_input_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .resume_valid (resume_valid),
    .resume_ready (resume_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rst_tb_valid (rst_tb_valid),
    .rst_tb_ready (rst_tb_ready),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .dma_valid    (dma_valid),
    .dma_ready    (dma_ready),
    .req_stall    (req_stall),
    .flush_stall  (flush_stall),
    .rst_done     (rst_done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sel      (out_sel),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] rdy_vec();
    return {resume_ready, rsp_ready, rst_tb_ready, req_ready, dma_ready};
  endfunction

  function automatic logic [4:0] code_vec(input int c);
    logic [4:0] top;
    top = 5'b10000;
    if (c == 0) return 5'b00000;
    return top >> (c - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    resume_valid = 0; rsp_valid = 0; rst_tb_valid = 0; req_valid = 0; dma_valid = 0;
    req_stall = 0; flush_stall = 0; rst_done = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    resume_valid = 1; rsp_valid = 1; rst_tb_valid = 1; req_valid = 1; dma_valid = 1;
    out_ready = 1;
    #1;
    checks++;
    if (rdy_vec() !== 5'b0) begin
      errors++; $display("FAIL reset_ready got=%b exp=00000", rdy_vec());
    end
    tick();
    checks++;
    if ({out_valid, out_sel, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_state got v=%b sel=%0d busy=%b exp 0/0/0", out_valid, out_sel, busy);
    end
    rst = 0;
    clear_inputs();
  endtask

  // priority, backpressure and flush blocking as one continuous scenario
  task automatic test_priority_backpressure_flush();
    do_reset();
    resume_valid = 1; rsp_valid = 1; rst_tb_valid = 1; req_valid = 1; dma_valid = 1;
    #1;
    checks++;
    if (rdy_vec() !== 5'b10000) begin errors++; $display("FAIL prio_all got=%b exp=10000", rdy_vec()); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 3'd1) begin errors++; $display("FAIL prio_sel1 got v=%b sel=%0d exp 1/1", out_valid, out_sel); end
    resume_valid = 0;
    #1;
    checks++;
    if (rdy_vec() !== 5'b01000) begin errors++; $display("FAIL prio_rsp got=%b exp=01000", rdy_vec()); end
    tick();
    checks++;
    if (out_sel !== 3'd2) begin errors++; $display("FAIL prio_sel2 got=%0d exp=2", out_sel); end
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rdy_vec() !== 5'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=00000", i, rdy_vec()); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 3'd2) begin errors++; $display("FAIL bp_hold[%0d] got v=%b sel=%0d exp 1/2", i, out_valid, out_sel); end
    end
    rsp_valid = 0; out_ready = 1;
    #1;
    checks++;
    if (rdy_vec() !== 5'b00100) begin errors++; $display("FAIL bp_release got=%b exp=00100", rdy_vec()); end
    tick();
    checks++;
    if (out_sel !== 3'd3 || busy !== 1'b1) begin errors++; $display("FAIL flush_enter got sel=%0d busy=%b exp 3/1", out_sel, busy); end
    #1;
    checks++;
    if (rdy_vec() !== 5'b0) begin errors++; $display("FAIL flush_block got=%b exp=00000", rdy_vec()); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_idle got v=%b busy=%b exp 0/1", out_valid, busy); end
    rsp_valid = 1;
    #1;
    checks++;
    if (rdy_vec() !== 5'b01000) begin errors++; $display("FAIL flush_rsp got=%b exp=01000", rdy_vec()); end
    tick();
    rsp_valid = 0; rst_done = 1;
    #1;
    checks++;
    if (rdy_vec() !== 5'b0) begin errors++; $display("FAIL flush_done_cycle got=%b exp=00000", rdy_vec()); end
    tick();
    rst_done = 0; rst_tb_valid = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_exit busy got=%b exp=0", busy); end
    #1;
    checks++;
    if (rdy_vec() !== 5'b00010) begin errors++; $display("FAIL flush_req got=%b exp=00010", rdy_vec()); end
    tick();
    checks++;
    if (out_sel !== 3'd4) begin errors++; $display("FAIL flush_req_sel got=%0d exp=4", out_sel); end
    clear_inputs();
  endtask

  task automatic test_starvation();
    do_reset();
    rsp_valid = 1; dma_valid = 1;
    for (int r = 1; r <= 20; r++) begin
      #1;
      checks++;
      if (rdy_vec() !== 5'b01000) begin errors++; $display("FAIL starve_rsp round %0d got=%b exp=01000", r, rdy_vec()); end
      tick();
    end
    do_reset();
    req_valid = 1; dma_valid = 1;
    for (int r = 1; r <= 18; r++) begin
      #1;
      checks++;
      if (rdy_vec() !== ((r == 9 || r == 18) ? 5'b00001 : 5'b00010)) begin
        errors++; $display("FAIL starve_dma round %0d got=%b", r, rdy_vec());
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_stalls();
    do_reset();
    rsp_valid = 1;
    tick();
    rsp_valid = 0; req_valid = 1; req_stall = 1;
    #1;
    checks++;
    if (rdy_vec() !== 5'b0) begin errors++; $display("FAIL req_stall got=%b exp=00000", rdy_vec()); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_sel !== 3'd0) begin errors++; $display("FAIL req_stall_out got v=%b sel=%0d exp 0/0", out_valid, out_sel); end
    req_valid = 0; req_stall = 0; dma_valid = 1;
    #1;
    checks++;
    if (rdy_vec() !== 5'b00001) begin errors++; $display("FAIL dma_free got=%b exp=00001", rdy_vec()); end
    flush_stall = 1;
    #1;
    checks++;
    if (rdy_vec() !== 5'b0) begin errors++; $display("FAIL flush_stall_dma got=%b exp=00000", rdy_vec()); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 1; dma_valid = 1;
    tick(); tick();
    rst_tb_valid = 1;
    tick();
    out_ready = 0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got busy=%b v=%b exp 1/1", busy, out_valid); end
    rst = 1;
    #1;
    checks++;
    if (rdy_vec() !== 5'b0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=00000", rdy_vec()); end
    tick();
    rst = 0; rst_tb_valid = 0; out_ready = 1;
    checks++;
    if ({out_valid, out_sel, busy} !== 5'b0) begin errors++; $display("FAIL mid_rst_state got v=%b sel=%0d busy=%b exp 0/0/0", out_valid, out_sel, busy); end
    for (int r = 1; r <= 9; r++) begin
      #1;
      checks++;
      if (rdy_vec() !== ((r == 9) ? 5'b00001 : 5'b00010)) begin
        errors++; $display("FAIL mid_cnt_cleared round %0d got=%b", r, rdy_vec());
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    bit load;
    int win;
    logic [4:0] exp_vec;
    do_reset();
    m_valid = 0; m_sel = 0; m_blk = 0; m_req_cnt = 0; m_dma_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      resume_valid = ($urandom_range(0, 9) < 2);
      rsp_valid    = ($urandom_range(0, 9) < 2);
      rst_tb_valid = ($urandom_range(0, 9) < 3);
      req_valid    = ($urandom_range(0, 9) < 6);
      dma_valid    = ($urandom_range(0, 9) < 6);
      req_stall    = ($urandom_range(0, 3) == 0);
      flush_stall  = ($urandom_range(0, 5) == 0);
      rst_done     = ($urandom_range(0, 4) == 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      #1;
      load = !m_valid || out_ready;
      can[0] = 0;
      can[1] = resume_valid;
      can[2] = rsp_valid;
      can[3] = rst_tb_valid && !m_blk;
      can[4] = req_valid && !req_stall && !flush_stall && !m_blk;
      can[5] = dma_valid && !flush_stall && !m_blk;
      if (can[5] && m_dma_cnt == LIMIT) order = '{1, 2, 5, 3, 4};
      else if (can[4] && m_req_cnt == LIMIT) order = '{1, 2, 4, 3, 5};
      else order = '{1, 2, 3, 4, 5};
      win = 0;
      for (int k = 0; k < 5; k++) if (win == 0 && can[order[k]]) win = order[k];
      exp_vec = (rst || !load) ? 5'b0 : code_vec(win);
      checks++;
      if (rdy_vec() !== exp_vec) begin
        errors++; $display("FAIL rand_ready cyc %0d got=%b exp=%b", i, rdy_vec(), exp_vec);
      end
      if (rst) begin
        m_valid = 0; m_sel = 0; m_blk = 0; m_req_cnt = 0; m_dma_cnt = 0;
      end else begin
        if (m_blk && rst_done) m_blk = 0;
        if (load) begin
          if (win == 4) m_req_cnt = 0;
          else if (can[4] && m_req_cnt < LIMIT) m_req_cnt++;
          if (win == 5) m_dma_cnt = 0;
          else if (can[5] && m_dma_cnt < LIMIT) m_dma_cnt++;
          if (win == 3) m_blk = 1;
          m_valid = (win != 0);
          m_sel   = win;
        end
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_sel !== m_sel[2:0] || busy !== m_blk) begin
        errors++; $display("FAIL rand_out cyc %0d got v=%b sel=%0d busy=%b exp v=%b sel=%0d busy=%b",
                           i, out_valid, out_sel, busy, m_valid, m_sel, m_blk);
      end
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_priority_backpressure_flush();
    test_starvation();
    test_stalls();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
